muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit between register file read ports and writeback mux.
//   Takes rs1/rs2 operand data plus funct3, runs a fixed-latency shift-add / restoring-divide loop,
//   and returns a result with its destination register index for the register-file write port.
//   Stalls the core via stall while busy; done doubles as the register write enable.
// PARAMETERS
//   XLEN      32   operand/result width; iteration count = XLEN
// PORTS
//   clk          in   1     clock, rising edge
//   rst          in   1     reset, asynchronous, active-high
//   start        in   1     request; sampled only in IDLE
//   kill         in   1     abort current op (pipeline flush)
//   funct3       in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   rs1_data     in   XLEN  operand A (dividend / multiplicand)
//   rs2_data     in   XLEN  operand B (divisor / multiplier)
//   rd_in        in   5     destination register index
//   busy         out  1     state is CALC or FIX
//   stall        out  1     (IDLE & start & ~kill) | busy; combinational
//   done         out  1     one-cycle pulse, result valid
//   result       out  XLEN  result; held until next accepted start
//   rd_out       out  5     latched rd_in; valid with done
//   reg_write    out  1     done & (rd_out != 0)
// BEHAVIOUR
//   Reset: state=IDLE; busy,done,reg_write=0; result=0; rd_out=0; counter=0.
//   States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start & ~kill at edge -> latch funct3, rd_in, |operands|, sign flags; CALC, cnt=0.
//   CALC: one iteration per cycle; cnt+1; after XLEN iterations (cnt==XLEN-1 at edge) -> FIX.
//   FIX: apply sign correction, select hi/lo/quotient/remainder, register result -> DONE.
//   DONE: done=1 for exactly one cycle; -> IDLE. start in DONE ignored (stall low this cycle).
//   Latency: start high in cycle 0 -> CALC cycles 1..XLEN, FIX cycle XLEN+1, done in XLEN+2 (34).
//   Fixed latency for all ops incl. special cases; no early termination.
//   Multiply: 2*XLEN product. MUL=low XLEN; MULH s*s, MULHSU s(rs1)*u(rs2), MULHU u*u -> high XLEN.
//   Signed ops: operate on magnitudes; negate in FIX if signs differ (quotient/product)
//     or if dividend negative (remainder). -2^XLEN-1 magnitude handled as unsigned 2^(XLEN-1).
//   Divide by zero (rs2==0): DIV/DIVU -> all ones; REM/REMU -> rs1 unchanged.
//   Signed overflow (rs1=0x8000_0000, rs2=-1): DIV -> 0x8000_0000; REM -> 0.
//   kill: any state -> IDLE at next edge; no done; result retains previous value.
//   kill and start same cycle in IDLE: start ignored.
//   rst mid-operation: immediate IDLE, outputs to reset values, no done.
//   start while busy: ignored; operands only captured in IDLE.
//   rd_in==0: op runs normally, done pulses, reg_write stays 0.
// TESTING
//   MUL 7*-3 (0x7, 0xFFFF_FFFD), rd=5 -> done in cycle 34, result 0xFFFF_FFEB, rd_out 5, reg_write 1.
//   MULH/MULHSU/MULHU 0x8000_0000*0xFFFF_FFFF -> 0x0000_0000 / 0x8000_0000 / 0x7FFF_FFFF.
//   DIV -20/3 -> 0xFFFF_FFFA; REM -20/3 -> 0xFFFF_FFFE; DIVU 20/3 -> 6; REMU 20/3 -> 2.
//   DIV/REM by 0 with rs1=0x1234 -> 0xFFFF_FFFF / 0x1234; DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0.
//   start DIVU mid-op, then kill in cycle 10 -> IDLE in cycle 11, no done, result unchanged, stall low.
//   rst pulse in cycle 20 of MUL -> busy/done/result 0 immediately; new start after rst -> correct result.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, fixed XLEN+2 cycle latency
// Shift-add multiply and restoring divide on operand magnitudes, sign fixed up after the loop.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_op, r_hi, r_lo, r_result;
  logic            r_neg;

  logic            w_accept, w_s1, w_s2, w_div0, w_neg, w_ge;
  logic [XLEN-1:0] w_mag1, w_mag2, w_diff, w_quo, w_rem, w_fix;
  logic [XLEN:0]   w_sum, w_shift;
  logic [2*XLEN-1:0] w_prod;

  assign w_accept = (r_state == S_IDLE) & start & ~kill;
  assign w_s1     = rs1_data[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]));
  assign w_s2     = rs2_data[XLEN-1] & ((funct3 == 3'b001) | (funct3[2] & ~funct3[0]));
  assign w_mag1   = w_s1 ? -rs1_data : rs1_data;
  assign w_mag2   = w_s2 ? -rs2_data : rs2_data;
  assign w_div0   = (rs2_data == '0);
  // Remainder follows the dividend sign; a zero divisor must leave the all-ones quotient unsigned.
  assign w_neg    = funct3[2] ? (funct3[1] ? w_s1 : ((w_s1 ^ w_s2) & ~w_div0)) : (w_s1 ^ w_s2);

  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
  assign w_shift  = {r_hi, r_lo[XLEN-1]};
  assign w_ge     = (w_shift >= {1'b0, r_op});
  assign w_diff   = w_shift[XLEN-1:0] - r_op;

  assign w_prod   = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo    = r_neg ? -r_lo : r_lo;
  assign w_rem    = r_neg ? -r_hi : r_hi;

  always_comb begin
    w_fix = w_rem;
    case (r_f3)
      3'b000:                 w_fix = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix = w_quo;
      default:                w_fix = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CALC;
      S_CALC:  if (r_cnt == CW'(XLEN-1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (kill) w_next = S_IDLE;
  end

  always_comb begin
    busy      = (r_state == S_CALC) | (r_state == S_FIX);
    done      = (r_state == S_DONE);
    stall     = w_accept | busy;
    reg_write = done & (r_rd != 5'd0);
  end

  // Multiply keeps the multiplier in r_lo; divide keeps the dividend there and shifts quotient bits in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_f3     <= '0;
      r_rd     <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_f3  <= funct3;
        r_rd  <= rd_in;
        r_op  <= funct3[2] ? w_mag2 : w_mag1;
        r_lo  <= funct3[2] ? w_mag1 : w_mag2;
        r_hi  <= '0;
        r_neg <= w_neg;
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_f3[2]) begin
          r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], w_ge};
        end else begin
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
        end
      end
      if ((r_state == S_FIX) && !kill) r_result <= w_fix;
    end
  end

  assign result = r_result;
  assign rd_out = r_rd;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, stall, done, reg_write;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .stall(stall), .done(done), .result(result),
    .rd_out(rd_out), .reg_write(reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    ea = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    sa = a;
    sb = b;
    case (f)
      3'b000:                 return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Reference timeline: m_age counts edges since an op was accepted (0 = no op in flight).
  int          m_age     = 0;
  logic [31:0] m_pending = '0;
  logic [31:0] m_result  = '0;
  logic [4:0]  m_rd      = '0;

  always @(negedge clk) begin
    logic e_busy, e_done, e_stall;
    if (rst) begin
      m_age = 0; m_result = '0; m_rd = '0;
    end
    e_busy  = (m_age >= 1) && (m_age <= XLEN + 1);
    e_done  = (m_age == LAT);
    e_stall = e_busy || ((m_age == 0) && start && !kill);
    check("busy", {31'b0, busy}, {31'b0, e_busy});
    check("done", {31'b0, done}, {31'b0, e_done});
    check("stall", {31'b0, stall}, {31'b0, e_stall});
    check("result", result, m_result);
    check("reg_write", {31'b0, reg_write}, {31'b0, e_done && (m_rd != 0)});
    if (e_done) check("rd_out", {27'b0, rd_out}, {27'b0, m_rd});
    if (!rst) begin
      if (m_age == 0) begin
        if (start && !kill) begin
          m_age = 1; m_pending = model(funct3, rs1_data, rs2_data); m_rd = rd_in;
        end
      end else if (kill || m_age == LAT) begin
        m_age = 0;
      end else begin
        m_age++;
        if (m_age == LAT) m_result = m_pending;
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom % 50;
      4:       return 32'h0 - ($urandom % 50);
      default: return $urandom;
    endcase
  endfunction

  // Called just after a rising edge; that cycle is cycle 0 of the op.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input string name, input int kill_at);
    int cyc;
    bit got, stop;
    start = 1'b1; kill = 1'b0; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    cyc = 1; got = 0; stop = 0;
    while (!stop) begin
      kill     = (cyc == kill_at);
      start    = (kill_at == 0) ? 1'($urandom) : 1'b0;
      funct3   = 3'($urandom);
      rs1_data = $urandom;
      rs2_data = $urandom;
      rd_in    = 5'($urandom);
      @(negedge clk);
      if (done) begin
        got = 1; stop = 1;
        if (kill_at == 0) begin
          check({name, "_result"}, result, exp);
          check({name, "_rd_out"}, {27'b0, rd_out}, {27'b0, rd});
        end
      end else if (cyc >= LAT + 6) begin
        stop = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (kill_at == 0) check({name, "_latency"}, cyc, LAT);
    else              check({name, "_no_done"}, {31'b0, got}, 32'h0);
    start = 1'b0; kill = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_result", result, 32'h0);
    check("reset_rd_out", {27'b0, rd_out}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);

    check("pin_mul", model(3'b000, 32'h7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("pin_mulhsu", model(3'b010, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_div", model(3'b100, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFA);
    check("pin_rem0", model(3'b110, 32'h1234, 32'h0), 32'h1234);

    do_op(3'b000, 32'h7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, "mul", 0);
    do_op(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, "mulh", 0);
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000, "mulhsu", 0);
    do_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h7FFF_FFFF, "mulhu", 0);
    do_op(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd6, 32'hFFFF_FFFA, "div", 0);
    do_op(3'b110, 32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFE, "rem", 0);
    do_op(3'b101, 32'd20, 32'd3, 5'd8, 32'd6, "divu", 0);
    do_op(3'b100, 32'h1234, 32'h0, 5'd9, 32'hFFFF_FFFF, "div0", 0);
    do_op(3'b110, 32'h1234, 32'h0, 5'd0, 32'h1234, "rem0_rd0", 0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, "div_ovf", 0);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0, "rem_ovf", 0);
    do_op(3'b111, 32'd20, 32'd3, 5'd12, 32'd2, "remu", 0);
    do_op(3'b101, 32'd1000, 32'd7, 5'd13, 32'h0, "divu_kill", 10);
    check("kill_result_held", result, 32'd2);
    check("kill_stall", {31'b0, stall}, 32'h0);

    start = 1'b1; funct3 = 3'b000; rs1_data = 32'd12345; rs2_data = 32'd678; rd_in = 5'd4;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    do_op(3'b000, 32'd12345, 32'd678, 5'd4, 32'd8369910, "mul_after_rst", 0);

    for (int i = 0; i < 45; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int          ka;
      f  = 3'($urandom);
      a  = pick();
      b  = pick();
      ka = (($urandom % 5) == 0) ? int'($urandom_range(33, 1)) : 0;
      do_op(f, a, b, 5'($urandom), model(f, a, b), "rand", ka);
      repeat ($urandom % 3) begin
        start = 1'($urandom);
        kill  = start;
        @(posedge clk); #1;
      end
      start = 1'b0; kill = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
